// File: rtl/vga_scan_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_engine_if
//  Purpose  : Video-RAM read bus between the scan engine and the framebuffer.
//             The engine (master) drives a cell column/row address and the
//             RAM (slave) returns the cell colour one Clock later.
//  Signals  : oReadCol   [COL_W]      cell column address   (master -> slave)
//             oReadRow   [ROW_W]      cell row address      (master -> slave)
//             iPixelData [COLOR_BITS] cell colour           (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface vga_scan_engine_if #(
  parameter int COL_W      = 6,
  parameter int ROW_W      = 6,
  parameter int COLOR_BITS = 3
);
  logic [COL_W-1:0]      oReadCol;
  logic [ROW_W-1:0]      oReadRow;
  logic [COLOR_BITS-1:0] iPixelData;

  modport master (output oReadCol, output oReadRow, input  iPixelData);
  modport slave  (input  oReadCol, input  oReadRow, output iPixelData);
endinterface
`default_nettype wire

// File: rtl/vga_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_engine
//  Purpose  : Parametrised VGA timing generator and framebuffer scan-out.
//             Divides Clock down to the pixel rate, produces H/V sync, issues
//             scaled cell read addresses for a window on screen and aligns the
//             returned RAM data with sync/blanking. Test-pattern modes:
//             0/3 framebuffer, 1 colour bars, 2 solid fill.
//  Ports    : Clock, Reset (async, active-low)
//             iMode        [2]          pattern select, latched at frame start
//             iBorderColor [COLOR_BITS] outside-window colour / solid fill
//             memBus       master       video RAM read address / data
//             oRGB         [COLOR_BITS] pixel to DAC
//             oHsync, oVsync            syncs, active level SYNC_POL
//             oHcounter, oVcounter [10] raw scan counters (pre-pipeline)
//             oFrameStart               one-Clock pulse with output pixel (0,0)
//  Revision : 1.0  initial release
// ============================================================================
module vga_scan_engine #(
  parameter int H_DISP      = 640,
  parameter int H_FP        = 16,
  parameter int H_PW        = 96,
  parameter int H_BP        = 48,
  parameter int V_DISP      = 480,
  parameter int V_FP        = 10,
  parameter int V_PW        = 2,
  parameter int V_BP        = 29,
  parameter int CLK_DIV     = 2,
  parameter int SCALE_SHIFT = 2,
  parameter int ORIGIN_X    = 100,
  parameter int ORIGIN_Y    = 100,
  parameter int WIN_W       = 60,
  parameter int WIN_H       = 40,
  parameter int COL_W       = 6,
  parameter int ROW_W       = 6,
  parameter int COLOR_BITS  = 3,
  parameter int SYNC_POL    = 0
) (
  input  wire                   Clock,
  input  wire                   Reset,
  input  wire [1:0]             iMode,
  input  wire [COLOR_BITS-1:0]  iBorderColor,
  vga_scan_engine_if.master     memBus,
  output logic [COLOR_BITS-1:0] oRGB,
  output logic                  oHsync,
  output logic                  oVsync,
  output logic [9:0]            oHcounter,
  output logic [9:0]            oVcounter,
  output logic                  oFrameStart
);

  localparam int c_H_TOTAL  = H_DISP + H_FP + H_PW + H_BP;
  localparam int c_V_TOTAL  = V_DISP + V_FP + V_PW + V_BP;
  localparam int c_HS_FIRST = H_DISP + H_FP;
  localparam int c_HS_LAST  = H_DISP + H_FP + H_PW - 1;
  localparam int c_VS_FIRST = V_DISP + V_FP;
  localparam int c_VS_LAST  = V_DISP + V_FP + V_PW - 1;
  localparam int c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic c_SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic c_SYNC_OFF = ~c_SYNC_ON;

  // --------------------------------------------------------------------------
  // Pixel-rate enable and raw scan counters
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div;
  logic [9:0]         r_hCount;
  logic [9:0]         r_vCount;
  logic               w_pe;
  logic               w_hWrap;
  logic               w_vWrap;

  // With CLK_DIV == 1 the divider never leaves 0 and w_pe is constantly high.
  assign w_pe    = (r_div == c_DIV_LAST);
  assign w_hWrap = (r_hCount == 10'(c_H_TOTAL - 1));
  assign w_vWrap = (r_vCount == 10'(c_V_TOTAL - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_div    <= '0;
      r_hCount <= '0;
      r_vCount <= '0;
    end else begin
      r_div <= w_pe ? '0 : r_div + c_DIV_W'(1);
      if (w_pe) begin
        if (w_hWrap) begin
          r_hCount <= '0;
          r_vCount <= w_vWrap ? '0 : r_vCount + 10'd1;
        end else begin
          r_hCount <= r_hCount + 10'd1;
        end
      end
    end
  end

  assign oHcounter = r_hCount;
  assign oVcounter = r_vCount;

  // --------------------------------------------------------------------------
  // Raw flags, window test and cell address for the current raw pixel
  // --------------------------------------------------------------------------
  logic [31:0] w_hExt;
  logic [31:0] w_vExt;
  logic [31:0] w_cellX;
  logic [31:0] w_cellY;
  logic        w_active;
  logic        w_inWin;
  logic        w_hsRaw;
  logic        w_vsRaw;
  logic        w_frameTop;

  assign w_hExt   = 32'(r_hCount);
  assign w_vExt   = 32'(r_vCount);
  // Only meaningful when the counter is at or past the origin; w_inWin
  // guards the underflowed case.
  assign w_cellX  = (w_hExt - 32'(ORIGIN_X)) >> SCALE_SHIFT;
  assign w_cellY  = (w_vExt - 32'(ORIGIN_Y)) >> SCALE_SHIFT;
  assign w_active = (w_hExt < 32'(H_DISP)) && (w_vExt < 32'(V_DISP));
  assign w_inWin  = w_active
                 && (w_hExt >= 32'(ORIGIN_X)) && (w_vExt >= 32'(ORIGIN_Y))
                 && (w_cellX < 32'(WIN_W))    && (w_cellY < 32'(WIN_H));
  assign w_hsRaw  = (w_hExt >= 32'(c_HS_FIRST)) && (w_hExt <= 32'(c_HS_LAST));
  assign w_vsRaw  = (w_vExt >= 32'(c_VS_FIRST)) && (w_vExt <= 32'(c_VS_LAST));
  assign w_frameTop = (r_hCount == 10'd0) && (r_vCount == 10'd0);

  // --------------------------------------------------------------------------
  // Pixel stage 1: address out to RAM, control flags travel alongside
  // --------------------------------------------------------------------------
  logic [COL_W-1:0]      r_readCol;
  logic [ROW_W-1:0]      r_readRow;
  logic                  r_s1Hs;
  logic                  r_s1Vs;
  logic                  r_s1Active;
  logic                  r_s1InWin;
  logic                  r_s1Fs;
  logic [COLOR_BITS-1:0] r_s1Bar;
  logic [1:0]            r_mode;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_readCol  <= '0;
      r_readRow  <= '0;
      r_s1Hs     <= 1'b0;
      r_s1Vs     <= 1'b0;
      r_s1Active <= 1'b0;
      r_s1InWin  <= 1'b0;
      r_s1Fs     <= 1'b0;
      r_s1Bar    <= '0;
      r_mode     <= 2'd0;
    end else if (w_pe) begin
      r_readCol  <= w_inWin ? COL_W'(w_cellX) : '0;
      r_readRow  <= w_inWin ? ROW_W'(w_cellY) : '0;
      r_s1Hs     <= w_hsRaw;
      r_s1Vs     <= w_vsRaw;
      r_s1Active <= w_active;
      r_s1InWin  <= w_inWin;
      r_s1Fs     <= w_frameTop;
      // Eight equal-width bars across the visible line.
      r_s1Bar    <= COLOR_BITS'((w_hExt << 3) / 32'(H_DISP));
      // Sampling the mode only at the top of the frame keeps a whole frame
      // in one pattern; it reaches the output together with pixel (0,0).
      if (w_frameTop) begin
        r_mode <= iMode;
      end
    end
  end

  assign memBus.oReadCol = r_readCol;
  assign memBus.oReadRow = r_readRow;

  // --------------------------------------------------------------------------
  // Data alignment: at one Clock per pixel the RAM answer arrives a full pixel
  // late, so the control flags get one more register to meet it.
  // --------------------------------------------------------------------------
  logic                  w_oHs;
  logic                  w_oVs;
  logic                  w_oActive;
  logic                  w_oInWin;
  logic                  w_oFs;
  logic [COLOR_BITS-1:0] w_oBar;
  logic [1:0]            w_oMode;

  generate
    if (CLK_DIV == 1) begin : g_align_two
      logic                  r_s2Hs;
      logic                  r_s2Vs;
      logic                  r_s2Active;
      logic                  r_s2InWin;
      logic                  r_s2Fs;
      logic [COLOR_BITS-1:0] r_s2Bar;
      logic [1:0]            r_s2Mode;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          r_s2Hs     <= 1'b0;
          r_s2Vs     <= 1'b0;
          r_s2Active <= 1'b0;
          r_s2InWin  <= 1'b0;
          r_s2Fs     <= 1'b0;
          r_s2Bar    <= '0;
          r_s2Mode   <= 2'd0;
        end else if (w_pe) begin
          r_s2Hs     <= r_s1Hs;
          r_s2Vs     <= r_s1Vs;
          r_s2Active <= r_s1Active;
          r_s2InWin  <= r_s1InWin;
          r_s2Fs     <= r_s1Fs;
          r_s2Bar    <= r_s1Bar;
          r_s2Mode   <= r_mode;
        end
      end

      assign w_oHs     = r_s2Hs;
      assign w_oVs     = r_s2Vs;
      assign w_oActive = r_s2Active;
      assign w_oInWin  = r_s2InWin;
      assign w_oFs     = r_s2Fs;
      assign w_oBar    = r_s2Bar;
      assign w_oMode   = r_s2Mode;
    end else begin : g_align_one
      assign w_oHs     = r_s1Hs;
      assign w_oVs     = r_s1Vs;
      assign w_oActive = r_s1Active;
      assign w_oInWin  = r_s1InWin;
      assign w_oFs     = r_s1Fs;
      assign w_oBar    = r_s1Bar;
      assign w_oMode   = r_mode;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic [COLOR_BITS-1:0] w_pixel;
  logic [COLOR_BITS-1:0] r_rgb;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_frameStart;

  always_comb begin
    w_pixel = '0;
    if (w_oActive) begin
      case (w_oMode)
        2'd1:    w_pixel = w_oBar;
        2'd2:    w_pixel = iBorderColor;
        default: w_pixel = w_oInWin ? memBus.iPixelData : iBorderColor;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rgb        <= '0;
      r_hsync      <= c_SYNC_OFF;
      r_vsync      <= c_SYNC_OFF;
      r_frameStart <= 1'b0;
    end else begin
      // Pulse only on the first Clock of pixel (0,0), not its whole period.
      r_frameStart <= w_pe & w_oFs;
      if (w_pe) begin
        r_rgb   <= w_pixel;
        r_hsync <= w_oHs ? c_SYNC_ON : c_SYNC_OFF;
        r_vsync <= w_oVs ? c_SYNC_ON : c_SYNC_OFF;
      end
    end
  end

  assign oRGB        = r_rgb;
  assign oHsync      = r_hsync;
  assign oVsync      = r_vsync;
  assign oFrameStart = r_frameStart;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scan_engine
//  Purpose  : Self-checking bench for vga_scan_engine on a miniature raster
//             (H 8/2/2/2, V 4/1/1/1, 14x7 = 98 pixels per frame).
//             dutS : CLK_DIV = 2, window at (2,1), 2x1 cells of 2x2 pixels.
//             dutF : CLK_DIV = 1, colour bars, same raster.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scan_engine;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] modeS = 2'd0;
  logic [1:0] modeF = 2'd1;
  logic [2:0] border = 3'b010;

  logic [2:0] rgbS, rgbF;
  logic       hsS, vsS, fsS, hsF, vsF, fsF;
  logic [9:0] hcS, vcS, hcF, vcF;

  vga_scan_engine_if #(.COL_W(6), .ROW_W(6), .COLOR_BITS(3)) busS ();
  vga_scan_engine_if #(.COL_W(6), .ROW_W(6), .COLOR_BITS(3)) busF ();

  vga_scan_engine #(
    .H_DISP(8), .H_FP(2), .H_PW(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
    .CLK_DIV(2), .SCALE_SHIFT(1), .ORIGIN_X(2), .ORIGIN_Y(1),
    .WIN_W(2), .WIN_H(1), .COL_W(6), .ROW_W(6), .COLOR_BITS(3), .SYNC_POL(0)
  ) dutS (
    .Clock(Clock), .Reset(Reset), .iMode(modeS), .iBorderColor(border),
    .memBus(busS), .oRGB(rgbS), .oHsync(hsS), .oVsync(vsS),
    .oHcounter(hcS), .oVcounter(vcS), .oFrameStart(fsS)
  );

  vga_scan_engine #(
    .H_DISP(8), .H_FP(2), .H_PW(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
    .CLK_DIV(1), .SCALE_SHIFT(1), .ORIGIN_X(2), .ORIGIN_Y(1),
    .WIN_W(2), .WIN_H(1), .COL_W(6), .ROW_W(6), .COLOR_BITS(3), .SYNC_POL(0)
  ) dutF (
    .Clock(Clock), .Reset(Reset), .iMode(modeF), .iBorderColor(border),
    .memBus(busF), .oRGB(rgbF), .oHsync(hsF), .oVsync(vsF),
    .oHcounter(hcF), .oVcounter(vcF), .oFrameStart(fsF)
  );

  always #5 Clock = ~Clock;

  // Registered-read RAM models; slow one returns an address-dependent colour.
  always @(posedge Clock) busS.iPixelData <= {2'b10, busS.oReadCol[0]};
  always @(posedge Clock) busF.iPixelData <= {busF.oReadRow[0], busF.oReadCol[1:0]};

  int nChecks = 0;
  int nPass   = 0;
  int edgeCnt = 0;
  int frameMode [8];
  int firstFsS = -1;
  int firstFsF = -1;
  int hsLowLine0 = 0;
  int vsLowFrame0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edgeCnt);
  endtask

  // Expected slow-DUT colour for output pixel q (q counts from reset release).
  // Window by hand: pixels 2..5 on lines 1..2, cell column (h-2)/2.
  function automatic int expRgbS(input int q);
    int h, v;
    h = q % 14;
    v = (q / 14) % 7;
    if (!(h < 8 && v < 4)) return 0;
    case (frameMode[q / 98])
      1:       return h;
      2:       return 3'b010;
      default: begin
        if (h >= 2 && h <= 5 && v >= 1 && v <= 2) return 4 + ((h - 2) / 2);
        return 3'b010;
      end
    endcase
  endfunction

  task automatic runAndCheck(input int n);
    int p, a, q, h, v, expCol;
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      edgeCnt++;
      @(negedge Clock);
      // ---- slow DUT: raw pixel p, address of pixel p-1, output of p-2
      p = edgeCnt / 2;
      check("hcountS", 32'(hcS), p % 14);
      check("vcountS", 32'(vcS), (p / 14) % 7);
      a = p - 1;
      expCol = 0;
      if (a >= 0) begin
        h = a % 14;
        v = (a / 14) % 7;
        if (h >= 2 && h <= 5 && v >= 1 && v <= 2) expCol = (h - 2) / 2;
      end
      check("readColS", 32'(busS.oReadCol), expCol);
      check("readRowS", 32'(busS.oReadRow), 0);
      q = p - 2;
      if (q < 0) begin
        check("rgbS", 32'(rgbS), 0);
        check("hsyncS", 32'(hsS), 1);
        check("vsyncS", 32'(vsS), 1);
        check("fsS", 32'(fsS), 0);
      end else begin
        h = q % 14;
        v = (q / 14) % 7;
        check("rgbS", 32'(rgbS), expRgbS(q));
        check("hsyncS", 32'(hsS), (h == 10 || h == 11) ? 0 : 1);
        check("vsyncS", 32'(vsS), (v == 5) ? 0 : 1);
        check("fsS", 32'(fsS), (edgeCnt % 2 == 0 && q % 98 == 0) ? 1 : 0);
      end
      if (fsS && firstFsS < 0) firstFsS = edgeCnt;
      if (edgeCnt >= 4 && edgeCnt <= 31 && !hsS) hsLowLine0++;
      if (edgeCnt >= 4 && edgeCnt <= 199 && !vsS) vsLowFrame0++;
      // ---- fast DUT: raw pixel e, output of pixel e-3, always colour bars
      check("hcountF", 32'(hcF), edgeCnt % 14);
      check("vcountF", 32'(vcF), (edgeCnt / 14) % 7);
      q = edgeCnt - 3;
      if (q < 0) begin
        check("rgbF", 32'(rgbF), 0);
        check("hsyncF", 32'(hsF), 1);
        check("vsyncF", 32'(vsF), 1);
        check("fsF", 32'(fsF), 0);
      end else begin
        h = q % 14;
        v = (q / 14) % 7;
        check("rgbF", 32'(rgbF), (h < 8 && v < 4) ? h : 0);
        check("hsyncF", 32'(hsF), (h == 10 || h == 11) ? 0 : 1);
        check("vsyncF", 32'(vsF), (v == 5) ? 0 : 1);
        check("fsF", 32'(fsF), (q % 98 == 0) ? 1 : 0);
      end
      if (fsF && firstFsF < 0) firstFsF = edgeCnt;
    end
  endtask

  initial begin
    frameMode = '{0, 0, 2, 1, 1, 1, 1, 1};
    #1 Reset = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_rgb", 32'(rgbS), 0);
    check("rst_hsync", 32'(hsS), 1);
    check("rst_vsync", 32'(vsS), 1);
    check("rst_col", 32'(busS.oReadCol), 0);
    check("rst_row", 32'(busS.oReadRow), 0);
    check("rst_fs", 32'(fsS), 0);
    check("rst_hcount", 32'(hcS), 0);
    check("rst_vcount", 32'(vcS), 0);
    #2 Reset = 1'b1;

    // Frames 0-1 framebuffer, switch to solid mid frame 1, to bars mid frame 2.
    runAndCheck(300);
    check("hsync_low_clocks_line0", hsLowLine0, 4);
    check("vsync_low_clocks_frame0", vsLowFrame0, 28);
    check("fs_first_slow", firstFsS, 4);
    check("fs_first_fast", firstFsF, 3);
    modeS = 2'd2;
    runAndCheck(200);
    modeS = 2'd1;
    runAndCheck(98);   // slow output now shows bar pixel 3, fast shows 7

    // Asynchronous reset between Clock edges.
    #1 Reset = 1'b0;
    #1;
    check("arst_rgbS", 32'(rgbS), 0);
    check("arst_hsyncS", 32'(hsS), 1);
    check("arst_vsyncS", 32'(vsS), 1);
    check("arst_hcountS", 32'(hcS), 0);
    check("arst_vcountS", 32'(vcS), 0);
    check("arst_colS", 32'(busS.oReadCol), 0);
    check("arst_fsS", 32'(fsS), 0);
    check("arst_rgbF", 32'(rgbF), 0);
    check("arst_hcountF", 32'(hcF), 0);

    frameMode = '{1, 1, 1, 1, 1, 1, 1, 1};
    edgeCnt  = 0;
    firstFsS = -1;
    firstFsF = -1;
    #1 Reset = 1'b1;
    runAndCheck(420);
    // Restart from (0,0): pixel (0,0) reaches the output on the second pixel
    // enable after release (slow), third Clock for the one-Clock-per-pixel build.
    check("fs_after_reset_slow", firstFsS, 4);
    check("fs_after_reset_fast", firstFsF, 3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
